oled_spi_fb: RTL
================

OLED_SPI_FB -- requirements
Module: oled_spi_fb

Interface
REQ-001 SHALL have parameter X_SIZE, default 128, meaning display columns (power of 2, 16..256).
REQ-002 SHALL have parameter Y_SIZE, default 64, meaning display rows (multiple of 8, power of 2); PAGES = Y_SIZE/8, derived.
REQ-003 SHALL have parameter INIT_MODE, default 2, meaning addressing mode after reset (0 horizontal, 1 vertical, 2 page).
REQ-004 SHALL have port clk_i, input, 1, meaning system clock; at least 4x scl_i frequency.
REQ-005 SHALL have port rst_i, input, 1, meaning reset; synchronous, active-low.
REQ-006 SHALL have ports ss_i, scl_i, mosi_i, dc_i, each input, 1, meaning SPI chip select (active-low), clock, data and data/command select (1 = data); all asynchronous to clk_i.
REQ-007 SHALL have port rd_addr_i, input, log2(PAGES)+log2(X_SIZE), meaning read address {page, column}.
REQ-008 SHALL have port rd_data_o, output, 8, meaning framebuffer byte; bit0 = top row of page.
REQ-009 SHALL have ports display_on_o and invert_o, each output, 1, and contrast_o, output, 8.
REQ-010 SHALL have port frame_o, output, 1, meaning one-cycle pulse when the write window wraps.

Function
REQ-011 SHALL pass ss_i, scl_i, mosi_i and dc_i through 2-FF synchronisers before any use.
REQ-012 SHALL sample mosi on each synchronised scl rising edge while ss low, MSB first, with a 3-bit bit counter.
REQ-013 SHALL clear the bit counter when ss goes high and discard the partial byte.
REQ-014 SHALL latch dc together with the 8th bit; the completed byte is data if dc=1, else command.
REQ-015 SHALL write a data byte to RAM[{page,col}] one cycle after completion, then advance the pointer.
REQ-016 Horizontal mode SHALL do col++; at col==col_end set col=col_start and page++; at page==page_end also set page=page_start and pulse frame_o.
REQ-017 Vertical mode SHALL do page++; at page==page_end set page=page_start and col++; at col==col_end also set col=col_start and pulse frame_o.
REQ-018 Page mode SHALL do col++ with wrap from X_SIZE-1 to 0, page unchanged; frame_o is never pulsed in page mode.
REQ-019 Command FSM SHALL have states IDLE, ARG1, ARG2, holding the pending opcode.
REQ-020 IDLE decode SHALL be:
  - 0x20: go to ARG1; arg[1:0] sets mode, where 3 is treated as 2.
  - 0x21 / 0x22: go to ARG1 then ARG2; the arguments set col_start/col_end (page_start/page_end), and col (page) is loaded with the start value.
  - 0x81: go to ARG1; arg sets contrast.
  - 0xA6 / 0xA7: invert = 0 / 1.
  - 0xAE / 0xAF: display_on = 0 / 1.
  - 0xB0+n: page = n.
  - 0x0n / 0x1n: set the low / high nibble of col.
  - 0xD5, 0xA8, 0xD3, 0x8D, 0xD9, 0xDB, 0xDA: consume one argument, discarded.
  - All other opcodes: ignored, stay IDLE.
REQ-021 SHALL mask column and page arguments to log2(X_SIZE) and log2(PAGES) bits.
REQ-022 SHALL let the FSM state persist across ss high periods, so arguments may span CS frames.
REQ-023 SHALL not write RAM and shall not advance the pointer on a data byte that completes while FSM is not IDLE; that byte is discarded.
REQ-024 SHALL register rd_data_o with 1-cycle latency; a read and write to the same address in the same cycle returns the old data.

Reset
REQ-025 On rst_i=0 at a clk_i edge, the block SHALL be reset as follows:
  - mode = INIT_MODE; col = page = 0.
  - col_start = 0, col_end = X_SIZE-1, page_start = 0, page_end = PAGES-1.
  - contrast_o = 0x7F; display_on_o = 0; invert_o = 0; frame_o = 0.
  - FSM = IDLE; bit counter = 0; synchronisers cleared.
REQ-026 Reset SHALL not clear RAM; rd_data_o is undefined until the first read after reset.
REQ-027 Reset asserted mid-byte or mid-argument SHALL abort it; no write and no register update.

Verification
REQ-028 Send cmd 0xAF then 0x81,0x40 -> display_on_o=1, contrast_o=0x40; invert_o stays 0.
REQ-029 Page mode: send cmds 0xB3,0x05,0x17, then data 0xAA,0x55 -> RAM[{3,0x75}]=0xAA, RAM[{3,0x76}]=0x55; read of {3,0x75} shows 0xAA on rd_data_o one cycle later.
REQ-030 Send cmds 0x20,0x00; 0x21,0x7E,0x7F; 0x22,0x06,0x07, then 4 data bytes -> writes land at {6,7E},{6,7F},{7,7E},{7,7F}; frame_o pulses once, after the 4th byte; pointer returns to {6,7E}.
REQ-031 Vertical mode (0x20,0x01), full window, 1024 data bytes -> column 0 pages 0..7 are filled first; exactly one frame_o pulse.
REQ-032 Raise ss after 5 bits, then send a full byte 0x3C as data -> only 0x3C is written; apply reset mid-argument of 0x81 -> contrast_o=0x7F and FSM back in IDLE.

Source files
------------

// File: rtl/oled_spi_fb.sv
// SPI-slave framebuffer for SSD1306-style OLED controllers: decodes the command
// subset, writes data bytes through an auto-advancing window pointer into RAM.
module oled_spi_fb #(
  parameter int unsigned X_SIZE    = 128,
  parameter int unsigned Y_SIZE    = 64,
  parameter int unsigned INIT_MODE = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      ss_i,
  input  logic                                      scl_i,
  input  logic                                      mosi_i,
  input  logic                                      dc_i,
  input  logic [((Y_SIZE/8 > 1) ? $clog2(Y_SIZE/8) : 1) + $clog2(X_SIZE)-1:0] rd_addr_i,
  output logic [7:0]                                rd_data_o,
  output logic                                      display_on_o,
  output logic                                      invert_o,
  output logic [7:0]                                contrast_o,
  output logic                                      frame_o
);

  localparam int unsigned PAGES = Y_SIZE / 8;
  localparam int unsigned CW    = $clog2(X_SIZE);
  localparam int unsigned PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned AW    = PW + CW;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [1:0] M_HORZ = 2'd0;
  localparam logic [1:0] M_VERT = 2'd1;
  localparam logic [1:0] M_PAGE = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ARG1, S_ARG2} state_e;

  // Synchroniser stages, bit order {dc, mosi, scl, ss}
  logic [3:0] sync1_q, sync2_q;
  logic       ss_s, scl_s, mosi_s, dc_s;
  logic       scl_prev_q;

  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_vld_q, byte_vld_d;
  logic          byte_dc_q, byte_dc_d;
  state_e        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [7:0]    contrast_q, contrast_d;
  logic          disp_q, disp_d, inv_q, inv_d, frame_q, frame_d;
  logic          we_c;
  logic [AW-1:0] waddr_c;
  logic [7:0]    col8_c;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem_q [DEPTH];

  assign {dc_s, mosi_s, scl_s, ss_s} = sync2_q;

  // Next-state logic: SPI shifter, command decoder and write pointer
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    byte_vld_d   = 1'b0;
    byte_dc_d    = byte_dc_q;
    state_d      = state_q;
    op_d         = op_q;
    mode_d       = mode_q;
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    contrast_d   = contrast_q;
    disp_d       = disp_q;
    inv_d        = inv_q;
    frame_d      = 1'b0;
    we_c         = 1'b0;
    waddr_c      = {page_q, col_q};
    col8_c       = 8'(col_q);

    if (ss_s) begin
      bit_cnt_d = 3'd0;
    end else if (scl_s && !scl_prev_q) begin
      shift_d   = {shift_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_vld_d = 1'b1;
        byte_d     = {shift_q, mosi_s};
        byte_dc_d  = dc_s;
      end
    end

    if (byte_vld_q) begin
      if (byte_dc_q) begin
        // Data bytes arriving mid-command are dropped without moving the pointer
        if (state_q == S_IDLE) begin
          we_c = 1'b1;
          case (mode_q)
            M_HORZ: begin
              if (col_q == col_end_q) begin
                col_d = col_start_q;
                if (page_q == page_end_q) begin
                  page_d  = page_start_q;
                  frame_d = 1'b1;
                end else begin
                  page_d = page_q + PW'(1);
                end
              end else begin
                col_d = col_q + CW'(1);
              end
            end
            M_VERT: begin
              if (page_q == page_end_q) begin
                page_d = page_start_q;
                if (col_q == col_end_q) begin
                  col_d   = col_start_q;
                  frame_d = 1'b1;
                end else begin
                  col_d = col_q + CW'(1);
                end
              end else begin
                page_d = page_q + PW'(1);
              end
            end
            default: col_d = col_q + CW'(1);
          endcase
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (byte_q[7:4] == 4'hB) begin
              page_d = PW'(byte_q[3:0]);
            end else if (byte_q[7:4] == 4'h0) begin
              col8_c[3:0] = byte_q[3:0];
              col_d       = CW'(col8_c);
            end else if (byte_q[7:4] == 4'h1) begin
              col8_c[7:4] = byte_q[3:0];
              col_d       = CW'(col8_c);
            end else begin
              case (byte_q)
                8'h20, 8'h21, 8'h22, 8'h81,
                8'hD5, 8'hA8, 8'hD3, 8'h8D, 8'hD9, 8'hDB, 8'hDA: begin
                  state_d = S_ARG1;
                  op_d    = byte_q;
                end
                8'hA6:   inv_d  = 1'b0;
                8'hA7:   inv_d  = 1'b1;
                8'hAE:   disp_d = 1'b0;
                8'hAF:   disp_d = 1'b1;
                default: ;
              endcase
            end
          end
          S_ARG1: begin
            state_d = S_IDLE;
            case (op_q)
              8'h20: mode_d = (byte_q[1:0] == 2'd3) ? M_PAGE : byte_q[1:0];
              8'h21: begin
                col_start_d = CW'(byte_q);
                col_d       = CW'(byte_q);
                state_d     = S_ARG2;
              end
              8'h22: begin
                page_start_d = PW'(byte_q);
                page_d       = PW'(byte_q);
                state_d      = S_ARG2;
              end
              8'h81:   contrast_d = byte_q;
              default: ;
            endcase
          end
          S_ARG2: begin
            state_d = S_IDLE;
            if (op_q == 8'h21) col_end_d = CW'(byte_q);
            else if (op_q == 8'h22) page_end_d = PW'(byte_q);
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      scl_prev_q   <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_vld_q   <= 1'b0;
      byte_dc_q    <= 1'b0;
      state_q      <= S_IDLE;
      op_q         <= '0;
      mode_q       <= 2'(INIT_MODE);
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(X_SIZE - 1);
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      contrast_q   <= 8'h7F;
      disp_q       <= 1'b0;
      inv_q        <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      sync1_q      <= {dc_i, mosi_i, scl_i, ss_i};
      sync2_q      <= sync1_q;
      scl_prev_q   <= scl_s;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      byte_vld_q   <= byte_vld_d;
      byte_dc_q    <= byte_dc_d;
      state_q      <= state_d;
      op_q         <= op_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      contrast_q   <= contrast_d;
      disp_q       <= disp_d;
      inv_q        <= inv_d;
      frame_q      <= frame_d;
    end
  end

  // Framebuffer: survives reset; read port returns pre-write data on a collision
  always_ff @(posedge clk_i) begin
    if (we_c && rst_i) mem_q[waddr_c] <= byte_q;
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o    = rd_data_q;
  assign display_on_o = disp_q;
  assign invert_o     = inv_q;
  assign contrast_o   = contrast_q;
  assign frame_o      = frame_q;

endmodule
